// File: rtl/branch_resolve_if.sv
// Instruction/flag inputs and branch outputs shared between the decode
// front end (master) and the branch_resolve stage (slave).
interface branch_resolve_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        flags_we;
    logic        cbz_zero;
    logic        uncondBr;
    logic        brTaken;
    logic [18:0] condAddr19;
    logic [25:0] brAddr26;
    logic        flush;
    logic [3:0]  flags_q;

    modport master (
        output instr_valid, instr, alu_flags, flags_we, cbz_zero,
        input  uncondBr, brTaken, condAddr19, brAddr26, flush, flags_q
    );

    modport slave (
        input  instr_valid, instr, alu_flags, flags_we, cbz_zero,
        output uncondBr, brTaken, condAddr19, brAddr26, flush, flags_q
    );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution: decodes B / B.cond / CBZ, holds NZCV and squashes wrong-path
// slots after a taken branch. Define BRANCH_FLAG_FWD_EN to forward same-cycle ALU flags to B.cond.
module branch_resolve #(
    parameter logic [2:0] FLUSH_CYCLES = 3'd2
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolve_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // cond encoding: bits [3:1] select the test, bit 0 inverts it (except AL/NV)
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, res;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond[3:1])
            3'd0:    res = z;
            3'd1:    res = c;
            3'd2:    res = n;
            3'd3:    res = v;
            3'd4:    res = c & ~z;
            3'd5:    res = (n == v);
            3'd6:    res = ~z & (n == v);
            3'd7:    res = 1'b1;
            default: res = 1'b0;
        endcase
        if (cond[0] && (cond[3:1] != 3'd7)) begin
            res = ~res;
        end else begin
            res = res;
        end
        return res;
    endfunction

    state_t      state_r, state_next_s;
    logic [2:0]  cnt_r, cnt_next_s;
    logic        uncond_r, uncond_next_s;
    logic        taken_r, taken_next_s;
    logic [18:0] cond_addr_r, cond_addr_next_s;
    logic [25:0] br_addr_r, br_addr_next_s;
    logic [3:0]  flags_r, flags_next_s;
    logic        flush_r;
    logic [3:0]  eval_flags_s;
    logic        is_b_s, is_bcond_s, is_cbz_s;

    assign is_b_s     = (bus.instr[31:26] == 6'b000101);
    assign is_bcond_s = (bus.instr[31:24] == 8'b01010100) && (bus.instr[4] == 1'b0);
    assign is_cbz_s   = (bus.instr[31:24] == 8'b10110100);

`ifdef BRANCH_FLAG_FWD_EN
    assign eval_flags_s = bus.flags_we ? bus.alu_flags : flags_r;
`else
    assign eval_flags_s = flags_r;
`endif

    // Next-state, flag update and branch-output decode
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        uncond_next_s    = 1'b0;
        taken_next_s     = 1'b0;
        cond_addr_next_s = cond_addr_r;
        br_addr_next_s   = br_addr_r;
        flags_next_s     = flags_r;
        case (state_r)
            ST_RUN: begin
                if (bus.flags_we) begin
                    flags_next_s = bus.alu_flags;
                end else begin
                    flags_next_s = flags_r;
                end
                if (bus.instr_valid && is_b_s) begin
                    uncond_next_s  = 1'b1;
                    taken_next_s   = 1'b1;
                    br_addr_next_s = bus.instr[25:0];
                end else if (bus.instr_valid && is_bcond_s) begin
                    taken_next_s     = cond_holds(bus.instr[3:0], eval_flags_s);
                    cond_addr_next_s = bus.instr[23:5];
                end else if (bus.instr_valid && is_cbz_s) begin
                    taken_next_s     = bus.cbz_zero;
                    cond_addr_next_s = bus.instr[23:5];
                end else begin
                    uncond_next_s = 1'b0;
                    taken_next_s  = 1'b0;
                end
                if (taken_next_s) begin
                    state_next_s = ST_FLUSH;
                    cnt_next_s   = FLUSH_CYCLES;
                end else begin
                    state_next_s = ST_RUN;
                    cnt_next_s   = cnt_r;
                end
            end
            ST_FLUSH: begin
                // Flags and instructions are ignored while wrong-path slots drain
                cnt_next_s = cnt_r - 3'd1;
                if (cnt_r == 3'd1) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            default: begin
                state_next_s = ST_RUN;
                cnt_next_s   = 3'd0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_RUN;
            cnt_r       <= 3'd0;
            uncond_r    <= 1'b0;
            taken_r     <= 1'b0;
            cond_addr_r <= 19'd0;
            br_addr_r   <= 26'd0;
            flags_r     <= 4'd0;
            flush_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            uncond_r    <= uncond_next_s;
            taken_r     <= taken_next_s;
            cond_addr_r <= cond_addr_next_s;
            br_addr_r   <= br_addr_next_s;
            flags_r     <= flags_next_s;
            flush_r     <= (state_next_s == ST_FLUSH);
        end
    end

    assign bus.uncondBr   = uncond_r;
    assign bus.brTaken    = taken_r;
    assign bus.condAddr19 = cond_addr_r;
    assign bus.brAddr26   = br_addr_r;
    assign bus.flush      = flush_r;
    assign bus.flags_q    = flags_r;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (FLUSH_CYCLES = 2); expectations
// for the same-cycle flag case follow BRANCH_FLAG_FWD_EN.
module tb_branch_resolve;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    branch_resolve_if bus_if ();

    branch_resolve #(.FLUSH_CYCLES(3'd2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [31:0] word);
        bus_if.instr_valid = valid;
        bus_if.instr       = word;
    endtask

    localparam logic [31:0] NOP = 32'h8B02_0020;

    initial begin
        logic same_cycle_exp;
`ifdef BRANCH_FLAG_FWD_EN
        same_cycle_exp = 1'b1;
`else
        same_cycle_exp = 1'b0;
`endif
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        drive(1'b0, 32'd0);
        bus_if.alu_flags = 4'd0;
        bus_if.flags_we  = 1'b0;
        bus_if.cbz_zero  = 1'b0;

        // Reset state
        #12;
        check_eq("rst_uncond", {31'd0, bus_if.uncondBr}, 32'd0);
        check_eq("rst_taken", {31'd0, bus_if.brTaken}, 32'd0);
        check_eq("rst_cond_addr", {13'd0, bus_if.condAddr19}, 32'd0);
        check_eq("rst_br_addr", {6'd0, bus_if.brAddr26}, 32'd0);
        check_eq("rst_flush", {31'd0, bus_if.flush}, 32'd0);
        check_eq("rst_flags", {28'd0, bus_if.flags_q}, 32'd0);
        reset = 1'b1;

        // Three non-branches
        drive(1'b1, NOP);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("nop_taken", {31'd0, bus_if.brTaken}, 32'd0);
            check_eq("nop_flush", {31'd0, bus_if.flush}, 32'd0);
        end

        // B imm26=12, then another B squashed inside the flush window
        drive(1'b1, 32'h1400_000C);
        tick();
        check_eq("b_uncond", {31'd0, bus_if.uncondBr}, 32'd1);
        check_eq("b_taken", {31'd0, bus_if.brTaken}, 32'd1);
        check_eq("b_addr", {6'd0, bus_if.brAddr26}, 32'd12);
        check_eq("b_flush1", {31'd0, bus_if.flush}, 32'd1);
        drive(1'b1, 32'h1400_0007);
        tick();
        check_eq("b_sq_taken1", {31'd0, bus_if.brTaken}, 32'd0);
        check_eq("b_flush2", {31'd0, bus_if.flush}, 32'd1);
        check_eq("b_sq_addr", {6'd0, bus_if.brAddr26}, 32'd12);
        tick();
        check_eq("b_sq_taken2", {31'd0, bus_if.brTaken}, 32'd0);
        check_eq("b_flush_end", {31'd0, bus_if.flush}, 32'd0);

        // Set Z, then B.EQ imm19=24 taken
        drive(1'b0, NOP);
        bus_if.flags_we  = 1'b1;
        bus_if.alu_flags = 4'b0100;
        tick();
        check_eq("flags_z", {28'd0, bus_if.flags_q}, 32'h4);
        bus_if.flags_we = 1'b0;
        drive(1'b1, 32'h5400_0300);
        tick();
        check_eq("beq_taken", {31'd0, bus_if.brTaken}, 32'd1);
        check_eq("beq_uncond", {31'd0, bus_if.uncondBr}, 32'd0);
        check_eq("beq_addr", {13'd0, bus_if.condAddr19}, 32'd24);
        check_eq("beq_flush", {31'd0, bus_if.flush}, 32'd1);
        drive(1'b0, NOP);
        tick();
        tick();
        check_eq("beq_flush_end", {31'd0, bus_if.flush}, 32'd0);

        // B.NE imm19=7 with Z set: not taken, no flush
        bus_if.flags_we  = 1'b1;
        bus_if.alu_flags = 4'b0100;
        tick();
        bus_if.flags_we = 1'b0;
        drive(1'b1, 32'h5400_00E1);
        tick();
        check_eq("bne_taken", {31'd0, bus_if.brTaken}, 32'd0);
        check_eq("bne_flush", {31'd0, bus_if.flush}, 32'd0);
        check_eq("bne_addr", {13'd0, bus_if.condAddr19}, 32'd7);

        // CBZ imm19=9 taken on the very next edge, then CBZ imm19=5 not taken
        drive(1'b1, 32'hB400_0120);
        bus_if.cbz_zero = 1'b1;
        tick();
        check_eq("cbz1_taken", {31'd0, bus_if.brTaken}, 32'd1);
        check_eq("cbz1_uncond", {31'd0, bus_if.uncondBr}, 32'd0);
        check_eq("cbz1_addr", {13'd0, bus_if.condAddr19}, 32'd9);
        drive(1'b0, NOP);
        tick();
        tick();
        drive(1'b1, 32'hB400_00A0);
        bus_if.cbz_zero = 1'b0;
        tick();
        check_eq("cbz0_taken", {31'd0, bus_if.brTaken}, 32'd0);
        check_eq("cbz0_addr", {13'd0, bus_if.condAddr19}, 32'd5);
        check_eq("cbz0_flush", {31'd0, bus_if.flush}, 32'd0);

        // Same-cycle flag write (Z=1) with B.EQ while flags_q.Z=0
        drive(1'b0, NOP);
        bus_if.flags_we  = 1'b1;
        bus_if.alu_flags = 4'b0000;
        tick();
        check_eq("flags_clr", {28'd0, bus_if.flags_q}, 32'h0);
        bus_if.alu_flags = 4'b0100;
        drive(1'b1, 32'h5400_0300);
        tick();
        bus_if.flags_we = 1'b0;
        check_eq("fwd_taken", {31'd0, bus_if.brTaken}, {31'd0, same_cycle_exp});
        check_eq("fwd_flush", {31'd0, bus_if.flush}, {31'd0, same_cycle_exp});
        check_eq("fwd_flags", {28'd0, bus_if.flags_q}, 32'h4);
        drive(1'b0, NOP);
        tick();
        tick();

        // flags_we during flush must not change flags_q
        drive(1'b1, 32'h1400_0010);
        tick();
        check_eq("fl_b_taken", {31'd0, bus_if.brTaken}, 32'd1);
        drive(1'b0, NOP);
        bus_if.flags_we  = 1'b1;
        bus_if.alu_flags = 4'b1000;
        tick();
        tick();
        bus_if.flags_we = 1'b0;
        check_eq("fl_flags_held", {28'd0, bus_if.flags_q}, 32'h4);

        // Reset in the second flush cycle aborts the flush asynchronously
        drive(1'b1, 32'h1400_0003);
        tick();
        check_eq("rf_flush1", {31'd0, bus_if.flush}, 32'd1);
        drive(1'b0, NOP);
        tick();
        check_eq("rf_flush2", {31'd0, bus_if.flush}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rf_flush_abort", {31'd0, bus_if.flush}, 32'd0);
        check_eq("rf_br_addr", {6'd0, bus_if.brAddr26}, 32'd0);
        check_eq("rf_flags", {28'd0, bus_if.flags_q}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 32'h1400_0005);
        tick();
        check_eq("rf_post_taken", {31'd0, bus_if.brTaken}, 32'd1);
        check_eq("rf_post_addr", {6'd0, bus_if.brAddr26}, 32'd5);
        check_eq("rf_post_flush", {31'd0, bus_if.flush}, 32'd1);
        drive(1'b0, NOP);
        tick();
        tick();
        check_eq("rf_post_flush_end", {31'd0, bus_if.flush}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
